// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one reg bus port between NumReq requesters.
// Define REG_BUS_ARBITER_TIMEOUT_EN to add the no-response watchdog.
package core_v_mcu_pkg;
    typedef struct packed {
        logic        valid;
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } reg_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
        logic        error;
    } reg_rsp_t;
endpackage

module reg_bus_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 255,
    parameter type         req_t         = core_v_mcu_pkg::reg_req_t,
    parameter type         rsp_t         = core_v_mcu_pkg::reg_rsp_t
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  req_t req_i [NumReq],
    output rsp_t rsp_o [NumReq],
    output req_t req_o,
    input  rsp_t rsp_i,
    output logic busy_o,
    output logic timeout_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic {IDLE, BUSY} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] gnt_q, gnt_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [IdxW-1:0] pick;
    logic            any_valid;
    logic            timeout;
    int unsigned     idx;

    // Search upward from the requester after the last winner.
    always_comb begin
        any_valid = 1'b0;
        pick      = '0;
        idx       = 0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            idx = (int'(last_q) + 1 + i) % NumReq;
            if (!any_valid && req_i[idx].valid) begin
                any_valid = 1'b1;
                pick      = IdxW'(idx);
            end
        end
    end

`ifdef REG_BUS_ARBITER_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (state_q != BUSY) begin
            cnt_q <= '0;
        end else if (!rsp_i.ready) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign timeout = (state_q == BUSY) && !rsp_i.ready &&
                     (cnt_q == CntW'(TimeoutCycles));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TimeoutCycles;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= IdxW'(NumReq - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        req_o   = '0;
        for (int unsigned k = 0; k < NumReq; k++) begin
            rsp_o[k] = '0;
        end
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    state_d = BUSY;
                    gnt_d   = pick;
                    last_d  = pick;
                end
            end
            BUSY: begin
                req_o        = req_i[gnt_q];
                rsp_o[gnt_q] = rsp_i;
                if (timeout) begin
                    req_o.valid        = 1'b0;
                    rsp_o[gnt_q]       = '0;
                    rsp_o[gnt_q].ready = 1'b1;
                    rsp_o[gnt_q].error = 1'b1;
                end
                // Completion, abandon and watchdog all release the grant.
                if (timeout || !req_i[gnt_q].valid || rsp_i.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o    = (state_q == BUSY);
    assign timeout_o = timeout;

endmodule
